// File: rtl/fwd_hazard_ctrl_if.sv
// Issue/operand/status bundle between the decode stage and the hazard controller.
// The decoder drives the master side and the controller sits on the slave side.
interface fwd_hazard_ctrl_if #(
    parameter int AW    = 4,
    parameter int NSRC  = 2,
    parameter int DEPTH = 3
);
    logic                  i_rdy;
    logic                  d_rdy;
    logic                  issue_vld;
    logic                  issue_we;
    logic                  issue_ld;
    logic [AW-1:0]         issue_dst;
    logic [NSRC-1:0]       src_re;
    logic [NSRC*AW-1:0]    src_addr;
    logic                  flow_change;
    logic                  hlt;
    logic                  pipe_stall;
    logic                  stall_id;
    logic                  bubble;
    logic                  flush;
    logic [NSRC*DEPTH-1:0] byp_sel;
    logic                  hlt_done;

    modport master (
        output i_rdy, d_rdy, issue_vld, issue_we, issue_ld, issue_dst,
               src_re, src_addr, flow_change, hlt,
        input  pipe_stall, stall_id, bubble, flush, byp_sel, hlt_done
    );

    modport slave (
        input  i_rdy, d_rdy, issue_vld, issue_we, issue_ld, issue_dst,
               src_re, src_addr, flow_change, hlt,
        output pipe_stall, stall_id, bubble, flush, byp_sel, hlt_done
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight RF writers past ID and derives
// load-use stalls, flow-change squash, halt drain and registered bypass selects.
module fwd_hazard_ctrl #(
    parameter int AW        = 4,
    parameter int NSRC      = 2,
    parameter int DEPTH     = 3,
    parameter int LD_LAT    = 1,
    parameter int FLUSH_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);
    localparam int FCW = $clog2(FLUSH_CYC + 2);
    localparam int HCW = $clog2(DEPTH + 2);

    typedef struct packed {
        logic          vld;
        logic          we;
        logic          ld;
        logic [AW-1:0] dst;
    } trk_t;

    trk_t [DEPTH-1:0]           trk_q, trk_d;
    logic [NSRC-1:0][DEPTH-1:0] byp_q, byp_d, first;
    logic [NSRC-1:0]            lu_port;
    logic [FCW-1:0]             fcnt_q, fcnt_d;
    logic [HCW-1:0]             hcnt_q, hcnt_d;
    logic                       clr_pend_q, clr_pend_d;
    logic                       hlt_pend_q, hlt_pend_d;
    logic                       pipe_stall, adv, load_use, flush, stall_id, accept;

    // Per port: youngest matching writer wins; the descending scan leaves the lowest j.
    always_comb begin
        first   = '0;
        lu_port = '0;
        for (int k = 0; k < NSRC; k++) begin
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (bus.src_re[k] && (bus.src_addr[k*AW +: AW] != '0) &&
                    trk_q[j].vld && trk_q[j].we &&
                    (trk_q[j].dst == bus.src_addr[k*AW +: AW])) begin
                    first[k]    = '0;
                    first[k][j] = 1'b1;
                    lu_port[k]  = trk_q[j].ld && (j < LD_LAT);
                end
            end
        end
    end

    assign pipe_stall = !bus.i_rdy || !bus.d_rdy;
    assign adv        = !pipe_stall;
    assign load_use   = |lu_port;
    assign flush      = bus.flow_change || (fcnt_q != '0);
    assign stall_id   = pipe_stall || load_use || hlt_pend_q;
    assign accept     = bus.issue_vld && !stall_id && !flush && !hlt_pend_q;

    always_comb begin
        trk_d      = trk_q;
        byp_d      = byp_q;
        fcnt_d     = fcnt_q;
        hcnt_d     = hcnt_q;
        clr_pend_d = clr_pend_q;
        hlt_pend_d = hlt_pend_q;
        if (adv) begin
            for (int j = DEPTH - 1; j > 0; j--) trk_d[j] = trk_q[j-1];
            trk_d[0] = accept ? {1'b1, bus.issue_we, bus.issue_ld, bus.issue_dst} : '0;
            // A flow change seen while frozen squashes on the first advance after it.
            if (bus.flow_change || clr_pend_q) begin
                for (int j = 0; j < FLUSH_CYC && j < DEPTH; j++) trk_d[j].vld = 1'b0;
            end
            clr_pend_d = 1'b0;
            byp_d      = accept ? first : '0;
            if (fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
            if (hlt_pend_q && (hcnt_q != HCW'(DEPTH))) hcnt_d = hcnt_q + 1'b1;
            if (accept && bus.hlt) hlt_pend_d = 1'b1;
        end else if (bus.flow_change) begin
            clr_pend_d = 1'b1;
        end
        if (bus.flow_change) fcnt_d = FCW'(FLUSH_CYC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_q      <= '0;
            byp_q      <= '0;
            fcnt_q     <= '0;
            hcnt_q     <= '0;
            clr_pend_q <= 1'b0;
            hlt_pend_q <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            byp_q      <= byp_d;
            fcnt_q     <= fcnt_d;
            hcnt_q     <= hcnt_d;
            clr_pend_q <= clr_pend_d;
            hlt_pend_q <= hlt_pend_d;
        end
    end

    assign bus.pipe_stall = pipe_stall;
    assign bus.stall_id   = stall_id;
    assign bus.bubble     = adv && !accept;
    assign bus.flush      = flush;
    assign bus.byp_sel    = byp_q;
    assign bus.hlt_done   = (hcnt_q == HCW'(DEPTH));
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an instruction-queue model.
module tb_fwd_hazard_ctrl;
    localparam int AW        = 4;
    localparam int NSRC      = 2;
    localparam int DEPTH     = 3;
    localparam int LD_LAT    = 1;
    localparam int FLUSH_CYC = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.AW(AW), .NSRC(NSRC), .DEPTH(DEPTH)) bus ();

    fwd_hazard_ctrl #(
        .AW(AW), .NSRC(NSRC), .DEPTH(DEPTH), .LD_LAT(LD_LAT), .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each in-flight instruction is a record aged by pipeline advances.
    typedef struct {
        int age;
        bit we;
        bit ld;
        int dst;
    } rec_t;

    rec_t q[$];
    int   exp_byp[NSRC];
    int   flush_left;
    bit   clr_pending;
    bit   halted;
    int   halt_adv;

    always @(negedge clk) begin
        bit   ps, lu, fl, sid, acc;
        int   hit_age[NSRC];
        bit   hit_ld[NSRC];
        int   a;
        rec_t r;
        logic [NSRC*DEPTH-1:0] eb;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < NSRC; k++) exp_byp[k] = -1;
            flush_left  = 0;
            clr_pending = 0;
            halted      = 0;
            halt_adv    = 0;
        end
        ps = !bus.i_rdy || !bus.d_rdy;
        lu = 0;
        for (int k = 0; k < NSRC; k++) begin
            hit_age[k] = -1;
            hit_ld[k]  = 0;
            a = int'(bus.src_addr[k*AW +: AW]);
            if (bus.src_re[k] && a != 0) begin
                foreach (q[i]) begin
                    if (q[i].we && q[i].dst == a && (hit_age[k] < 0 || q[i].age < hit_age[k])) begin
                        hit_age[k] = q[i].age;
                        hit_ld[k]  = q[i].ld;
                    end
                end
            end
            if (hit_age[k] >= 0 && hit_ld[k] && hit_age[k] < LD_LAT) lu = 1;
        end
        fl  = bus.flow_change || flush_left > 0;
        sid = ps || lu || halted;
        acc = bus.issue_vld && !sid && !fl;
        eb  = '0;
        for (int k = 0; k < NSRC; k++) if (exp_byp[k] >= 0) eb[k*DEPTH + exp_byp[k]] = 1'b1;
        check("m_pipe_stall", bus.pipe_stall, ps);
        check("m_stall_id", bus.stall_id, sid);
        check("m_bubble", bus.bubble, !ps && !acc);
        check("m_flush", bus.flush, fl);
        check("m_byp_sel", bus.byp_sel, eb);
        check("m_hlt_done", bus.hlt_done, halt_adv >= DEPTH);
        if (rst_n) begin
            if (!ps) begin
                foreach (q[i]) q[i].age++;
                for (int i = q.size() - 1; i >= 0; i--) if (q[i].age >= DEPTH) q.delete(i);
                if (acc) begin
                    r.age = 0;
                    r.we  = bus.issue_we;
                    r.ld  = bus.issue_ld;
                    r.dst = int'(bus.issue_dst);
                    q.push_back(r);
                end
                if (bus.flow_change || clr_pending)
                    for (int i = q.size() - 1; i >= 0; i--) if (q[i].age < FLUSH_CYC) q.delete(i);
                clr_pending = 0;
                for (int k = 0; k < NSRC; k++) exp_byp[k] = acc ? hit_age[k] : -1;
                if (bus.flow_change) flush_left = FLUSH_CYC;
                else if (flush_left > 0) flush_left--;
                if (halted && halt_adv < DEPTH) halt_adv++;
                if (acc && bus.hlt) halted = 1;
            end else if (bus.flow_change) begin
                flush_left  = FLUSH_CYC;
                clr_pending = 1;
            end
        end
    end

    task automatic idle();
        bus.i_rdy       = 1'b1;
        bus.d_rdy       = 1'b1;
        bus.issue_vld   = 1'b0;
        bus.issue_we    = 1'b0;
        bus.issue_ld    = 1'b0;
        bus.issue_dst   = '0;
        bus.src_re      = '0;
        bus.src_addr    = '0;
        bus.flow_change = 1'b0;
        bus.hlt         = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input bit we, input bit ld, input int dst);
        bus.issue_vld = 1'b1;
        bus.issue_we  = we;
        bus.issue_ld  = ld;
        bus.issue_dst = AW'(dst);
    endtask

    task automatic rd(input int k, input int a);
        bus.src_re[k]            = 1'b1;
        bus.src_addr[k*AW +: AW] = AW'(a);
    endtask

    task automatic drain();
        idle();
        repeat (DEPTH + 1) step();
    endtask

    function automatic logic [DEPTH-1:0] byp(input int k);
        return bus.byp_sel[k*DEPTH +: DEPTH];
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
        issue(0, 0, 1);
        #1;
        check("rst_stall_id", bus.stall_id, 0);
        check("rst_bubble", bus.bubble, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_byp", bus.byp_sel, 0);
        check("rst_hlt_done", bus.hlt_done, 0);

        // load-use on R3
        drain();
        issue(1, 1, 3);
        #1 check("lu_issue_bubble", bus.bubble, 0);
        step(); idle(); issue(0, 0, 7); rd(0, 3);
        #1;
        check("lu_stall_id", bus.stall_id, 1);
        check("lu_bubble", bus.bubble, 1);
        step();
        #1;
        check("lu_release", bus.stall_id, 0);
        check("lu_bubble_off", bus.bubble, 0);
        step();
        check("lu_byp", byp(0), 3'b010);

        // ALU forward then out of range
        drain();
        issue(1, 0, 5);
        step(); idle(); issue(0, 0, 1); rd(1, 5);
        #1 check("alu_no_stall", bus.stall_id, 0);
        step();
        check("alu_byp", byp(1), 3'b001);
        idle();
        step(); step();
        issue(0, 0, 1); rd(1, 5);
        step();
        check("alu_byp_gone", byp(1), 3'b000);

        // youngest wins; R0 never forwarded
        drain();
        issue(1, 0, 5); step();
        issue(1, 0, 5); step();
        idle(); issue(0, 0, 1); rd(0, 5); step();
        check("youngest_byp", byp(0), 3'b001);
        drain();
        issue(1, 0, 0); step();
        idle(); issue(0, 0, 1); rd(0, 0); step();
        check("r0_byp", byp(0), 3'b000);

        // flow change squashes two issues
        drain();
        issue(1, 0, 9); bus.flow_change = 1'b1;
        #1;
        check("fc_flush0", bus.flush, 1);
        check("fc_bubble0", bus.bubble, 1);
        step(); bus.flow_change = 1'b0;
        #1 check("fc_flush1", bus.flush, 1);
        step();
        #1 check("fc_flush2", bus.flush, 1);
        step();
        #1 check("fc_flush3", bus.flush, 0);
        idle(); issue(0, 0, 1); rd(0, 9); step();
        check("fc_no_byp", byp(0), 3'b000);

        // load-use coinciding with flow change
        drain();
        issue(1, 1, 3); step();
        idle(); issue(0, 0, 7); rd(0, 3); bus.flow_change = 1'b1;
        #1 check("lufc_stall", bus.stall_id, 1);
        step(); bus.flow_change = 1'b0;
        #1 check("lufc_no_stall", bus.stall_id, 0);
        step(); step();
        step();
        check("lufc_no_byp", byp(0), 3'b000);

        // data-memory stall during load-use
        drain();
        issue(1, 0, 5); step();
        idle(); issue(1, 1, 3); rd(0, 5); step();
        idle(); issue(0, 0, 7); rd(0, 3); bus.d_rdy = 1'b0;
        #1;
        check("dstall_pipe", bus.pipe_stall, 1);
        check("dstall_bubble", bus.bubble, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("dstall_frozen_byp", byp(0), 3'b001);
        end
        bus.d_rdy = 1'b1;
        #1;
        check("dstall_lu", bus.stall_id, 1);
        check("dstall_lu_bubble", bus.bubble, 1);
        step();
        #1 check("dstall_release", bus.stall_id, 0);
        step();
        check("dstall_byp", byp(0), 3'b010);

        // halt drain and reset mid-drain
        drain();
        issue(0, 0, 0); bus.hlt = 1'b1;
        step(); bus.hlt = 1'b0;
        #1 check("hlt_stall", bus.stall_id, 1);
        step(); step();
        check("hlt_not_done", bus.hlt_done, 0);
        step();
        check("hlt_done", bus.hlt_done, 1);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        #1 check("hlt_rst_done", bus.hlt_done, 0);
        bus.hlt = 1'b1; step(); bus.hlt = 1'b0; step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        #1;
        check("hlt_mid_done", bus.hlt_done, 0);
        check("hlt_mid_stall", bus.stall_id, 0);
        repeat (4) step();
        check("hlt_mid_stays", bus.hlt_done, 0);

        // randomized traffic, model checks each cycle
        for (int ph = 0; ph < 4; ph++) begin
            rst_n = 1'b0; idle(); step(); rst_n = 1'b1;
            for (int c = 0; c < 300; c++) begin
                bus.i_rdy       = ($urandom_range(9) != 0);
                bus.d_rdy       = ($urandom_range(9) != 0);
                bus.issue_vld   = ($urandom_range(3) != 0);
                bus.issue_we    = ($urandom_range(3) != 0);
                bus.issue_ld    = ($urandom_range(2) == 0);
                bus.issue_dst   = AW'($urandom_range(3));
                bus.src_re      = NSRC'($urandom);
                for (int k = 0; k < NSRC; k++) bus.src_addr[k*AW +: AW] = AW'($urandom_range(3));
                bus.flow_change = ($urandom_range(11) == 0);
                bus.hlt         = (ph >= 2) && ($urandom_range(79) == 0);
                rst_n           = ($urandom_range(199) != 0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
